// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_scan_display_if.sv
// Digit/strobe inputs and pin-level outputs of seg_scan_display.
// The blink enable vector exists only when SEG_BLINK_EN is defined.
interface seg_scan_display_if;
    import seg_pkg::*;

    logic                  load;
    logic [31:0]           digits;
    logic [3:0]            blank_lz;
    logic [NUM_DIGITS-1:0] dp;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0] blink;
`endif
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp_n;

`ifdef SEG_BLINK_EN
    modport master (output load, digits, blank_lz, dp, blink, input an, seg, dp_n);
    modport slave  (input load, digits, blank_lz, dp, blink, output an, seg, dp_n);
`else
    modport master (output load, digits, blank_lz, dp, input an, seg, dp_n);
    modport slave  (input load, digits, blank_lz, dp, output an, seg, dp_n);
`endif

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment code; A-F show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  bcd_t       nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit common-anode display driver with leading-zero blanking.
// Define SEG_BLINK_EN to add per-digit blinking driven by a frame counter.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 256
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_display_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

    logic [PW-1:0]         presc;
    logic [2:0]            idx;
    logic [31:0]           digits_sh;
    logic [3:0]            blz_sh;
    logic [NUM_DIGITS-1:0] dp_sh;
    logic                  slot_wrap;

    assign slot_wrap = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            digits_sh <= '0;
            blz_sh    <= '0;
            dp_sh     <= '0;
        end else begin
            presc <= slot_wrap ? '0 : presc + 1'b1;
            if (slot_wrap)
                idx <= idx + 3'd1;
            if (bus.load) begin
                digits_sh <= bus.digits;
                blz_sh    <= bus.blank_lz;
                dp_sh     <= bus.dp;
            end
        end
    end

    logic blink_hit;

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] frame_cnt;
    logic          phase;

    // A frame ends when the last digit's slot wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (slot_wrap && idx == 3'd7) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_hit = phase & bus.blink[idx];
`else
    assign blink_hit = 1'b0;
`endif

    // Stage p0: select and decode the digit for the current slot.
    bcd_t       nib_p0;
    logic [6:0] code_p0;
    logic       lz_hit_p0;
    logic       blank_p0;

    assign nib_p0    = digits_sh[{idx, 2'b00} +: 4];
    assign lz_hit_p0 = idx[0] && (nib_p0 == 4'd0) && blz_sh[idx[2:1]];
    assign blank_p0  = (presc < GUARD_END) || lz_hit_p0 || blink_hit;

    bcd_to_seg u_dec (
        .nib (nib_p0),
        .seg (code_p0)
    );

    // Stage p1: registered pin drivers.
    logic [NUM_DIGITS-1:0] an_p1;
    logic [6:0]            seg_p1;
    logic                  dpn_p1;

    always_ff @(posedge clk) begin
        if (rst || blank_p0) begin
            an_p1  <= '1;
            seg_p1 <= SEG_BLANK;
            dpn_p1 <= 1'b1;
        end else begin
            an_p1  <= ~(NUM_DIGITS'(1) << idx);
            seg_p1 <= code_p0;
            dpn_p1 <= ~dp_sh[idx];
        end
    end

    assign bus.an   = an_p1;
    assign bus.seg  = seg_p1;
    assign bus.dp_n = dpn_p1;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with REFRESH_DIV=4, GUARD=1, BLINK_DIV=2.
module tb_seg_scan_display;
    import seg_pkg::*;

    localparam int RD = 4;
    localparam int GD = 1;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   k = 0;    // edges since reset release; output after edge k shows slot position k-1

    seg_scan_display_if bus ();

    seg_scan_display #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [6:0] s, input logic d);
        return {16'h0, a, s, d};
    endfunction

    function automatic logic [31:0] outs();
        return {16'h0, bus.an, bus.seg, bus.dp_n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 32 && (k % 32) != p; i++) step();
    endtask

    task automatic load_vec(input logic [31:0] d, input logic [3:0] b, input logic [7:0] p);
        bus.digits   = d;
        bus.blank_lz = b;
        bus.dp       = p;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int d, input logic [31:0] exp);
        align(4 * d);
        step();
        chk({tag, "/guard"}, outs(), pk(8'hFF, 7'h7F, 1'b1));
        for (int j = 1; j < 4; j++) begin
            step();
            chk($sformatf("%s/p%0d", tag, j), outs(), exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst%0d", i), outs(), pk(8'hFF, 7'h7F, 1'b1));
        end
        rst = 1'b0;
        k = 0;
    endtask

    logic [6:0] scan_seg [8];

    initial begin
        scan_seg = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        bus.load     = 1'b0;
        bus.digits   = '0;
        bus.blank_lz = '0;
        bus.dp       = '0;
`ifdef SEG_BLINK_EN
        bus.blink    = '0;
`endif

        // Reset and first active digit at prescaler 1
        do_reset();
        step();
        chk("post_rst_guard", outs(), pk(8'hFF, 7'h7F, 1'b1));
        step();
        chk("first_digit", outs(), pk(8'hFE, 7'h40, 1'b1));

        // Scan order
        load_vec(32'h87654321, 4'h0, 8'h00);
        for (int d = 0; d < 8; d++)
            check_slot($sformatf("scan%0d", d), d, pk(~(8'h01 << d), scan_seg[d], 1'b1));

        // Leading-zero blanking
        load_vec(32'h00000005, 4'hF, 8'h00);
        check_slot("lz0", 0, pk(8'hFE, 7'h12, 1'b1));
        check_slot("lz1", 1, pk(8'hFF, 7'h7F, 1'b1));
        check_slot("lz2", 2, pk(8'hFB, 7'h40, 1'b1));
        load_vec(32'h00000005, 4'h0, 8'h00);
        check_slot("lz1_off", 1, pk(8'hFD, 7'h40, 1'b1));

        // Non-BCD nibble with decimal point
        load_vec(32'h0000000C, 4'h0, 8'h01);
        check_slot("dash_dp", 0, pk(8'hFE, 7'h3F, 1'b0));

        // Load mid-slot: visible two cycles after the strobe is driven
        load_vec(32'h00000001, 4'h0, 8'h00);
        align(0);
        step();
        chk("ld_guard", outs(), pk(8'hFF, 7'h7F, 1'b1));
        step();
        chk("ld_old", outs(), pk(8'hFE, 7'h79, 1'b1));
        bus.digits = 32'h00000009;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        chk("ld_still_old", outs(), pk(8'hFE, 7'h79, 1'b1));
        step();
        chk("ld_new", outs(), pk(8'hFE, 7'h10, 1'b1));

        // Load on the slot-wrap cycle lands in the new slot
        align(3);
        bus.digits = 32'h00000029;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
        chk("wrap_prev", outs(), pk(8'hFE, 7'h10, 1'b1));
        step();
        chk("wrap_guard", outs(), pk(8'hFF, 7'h7F, 1'b1));
        step();
        chk("wrap_new", outs(), pk(8'hFD, 7'h24, 1'b1));

        // Blink: mid-scan reset then six frames of digit 0
        do_reset();
`ifdef SEG_BLINK_EN
        bus.blink = 8'h01;
`endif
        load_vec(32'h00000001, 4'h0, 8'h00);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 256 && k < 32 * f + 2; i++) step();
`ifdef SEG_BLINK_EN
            if (((f / 2) % 2) == 1)
                chk($sformatf("blink_f%0d", f), outs(), pk(8'hFF, 7'h7F, 1'b1));
            else
                chk($sformatf("blink_f%0d", f), outs(), pk(8'hFE, 7'h79, 1'b1));
`else
            chk($sformatf("noblink_f%0d", f), outs(), pk(8'hFE, 7'h79, 1'b1));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
